// File: rtl/captura_operandos.sv
// ============================================================================
//  Module      : captura_operandos
//  Description : Keypad operand capture. Builds a 3-digit BCD entry from
//                filtered key strobes and commits it as operand A (key A)
//                and operand B (key #). Key B clears, and digits in LISTO
//                start a new operation. A silence counter suppresses
//                auto-repeat strobes of a held key.
//  Options     : KEY_BACKSPACE_EN - when defined, key C deletes the last
//                digit of the entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module captura_operandos #(
    parameter int RELEASE_CYCLES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dato,
    input  logic        dato_ctrl,
    output logic [11:0] disp,
    output logic [1:0]  n_dig,
    output logic [11:0] num_a,
    output logic [11:0] num_b,
    output logic [1:0]  fase,
    output logic        listo
);

    localparam int            c_cnt_w  = $clog2(RELEASE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_sat = c_cnt_w'(RELEASE_CYCLES);

    localparam logic [3:0] c_key_a    = 4'd10;
    localparam logic [3:0] c_key_b    = 4'd11;
`ifdef KEY_BACKSPACE_EN
    localparam logic [3:0] c_key_c    = 4'd12;
`endif
    localparam logic [3:0] c_key_hash = 4'd15;

    typedef enum logic [1:0] {
        INGRESO_A = 2'b00,
        INGRESO_B = 2'b01,
        LISTO     = 2'b10,
        ILEGAL    = 2'b11
    } fase_t;

    fase_t                r_fase;
    fase_t                w_fase_next;
    logic [11:0]          r_entry;
    logic [11:0]          w_entry_next;
    logic [1:0]           r_n_dig;
    logic [1:0]           w_n_dig_next;
    logic [11:0]          r_num_a;
    logic [11:0]          w_num_a_next;
    logic [11:0]          r_num_b;
    logic [11:0]          w_num_b_next;
    logic                 r_listo;
    logic                 w_listo_next;
    logic [3:0]           r_last;
    logic [3:0]           w_last_next;
    logic [c_cnt_w-1:0]   r_silence;
    logic [c_cnt_w-1:0]   w_silence_next;

    logic                 w_accept;
    logic                 w_is_digit;
    logic                 w_entry_full;

    // A strobe is a new press if the code changed or the key was released long enough
    assign w_accept     = dato_ctrl && ((dato != r_last) || (r_silence == c_sat));
    assign w_is_digit   = (dato <= 4'd9);
    assign w_entry_full = (r_n_dig == 2'd3);

    // State and datapath registers; reset discards any simultaneous strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fase    <= INGRESO_A;
            r_entry   <= 12'h000;
            r_n_dig   <= 2'd0;
            r_num_a   <= 12'h000;
            r_num_b   <= 12'h000;
            r_listo   <= 1'b0;
            r_last    <= 4'h0;
            r_silence <= c_sat;
        end else begin
            r_fase    <= w_fase_next;
            r_entry   <= w_entry_next;
            r_n_dig   <= w_n_dig_next;
            r_num_a   <= w_num_a_next;
            r_num_b   <= w_num_b_next;
            r_listo   <= w_listo_next;
            r_last    <= w_last_next;
            r_silence <= w_silence_next;
        end
    end

    // Next-state: repeat filter plus per-phase key decoding
    always_comb begin
        w_fase_next    = r_fase;
        w_entry_next   = r_entry;
        w_n_dig_next   = r_n_dig;
        w_num_a_next   = r_num_a;
        w_num_b_next   = r_num_b;
        w_listo_next   = 1'b0;
        w_last_next    = r_last;
        w_silence_next = r_silence;

        if (dato_ctrl) begin
            w_silence_next = '0;
        end else if (r_silence != c_sat) begin
            w_silence_next = r_silence + 1'b1;
        end

        if (w_accept) begin
            w_last_next = dato;
        end

        case (r_fase)
            INGRESO_A, INGRESO_B: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        // Full entry swallows further digits silently
                        if (!w_entry_full) begin
                            w_entry_next = {r_entry[7:0], dato};
                            w_n_dig_next = r_n_dig + 2'd1;
                        end
                    end else if ((dato == c_key_a) && (r_fase == INGRESO_A)) begin
                        w_num_a_next = r_entry;
                        w_entry_next = 12'h000;
                        w_n_dig_next = 2'd0;
                        w_fase_next  = INGRESO_B;
                    end else if ((dato == c_key_hash) && (r_fase == INGRESO_B)) begin
                        w_num_b_next = r_entry;
                        w_entry_next = 12'h000;
                        w_n_dig_next = 2'd0;
                        w_listo_next = 1'b1;
                        w_fase_next  = LISTO;
                    end else if (dato == c_key_b) begin
                        w_entry_next = 12'h000;
                        w_n_dig_next = 2'd0;
`ifdef KEY_BACKSPACE_EN
                    end else if ((dato == c_key_c) && (r_n_dig != 2'd0)) begin
                        w_entry_next = {4'h0, r_entry[11:4]};
                        w_n_dig_next = r_n_dig - 2'd1;
`endif
                    end
                end
            end
            LISTO: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        // Operands stay visible until the next commit overwrites them
                        w_entry_next = {8'h00, dato};
                        w_n_dig_next = 2'd1;
                        w_fase_next  = INGRESO_A;
                    end else if (dato == c_key_b) begin
                        w_num_a_next = 12'h000;
                        w_num_b_next = 12'h000;
                        w_entry_next = 12'h000;
                        w_n_dig_next = 2'd0;
                        w_fase_next  = INGRESO_A;
                    end
                end
            end
            default: begin
                w_fase_next = INGRESO_A;
            end
        endcase
    end

    // Display follows the entry while typing and the result operand when ready
    always_comb begin
        disp = (r_fase == LISTO) ? r_num_b : r_entry;
    end

    assign n_dig = r_n_dig;
    assign num_a = r_num_a;
    assign num_b = r_num_b;
    assign fase  = r_fase;
    assign listo = r_listo;

endmodule

`default_nettype wire

// File: tb/tb_captura_operandos.sv
// ============================================================================
//  Module      : tb_captura_operandos
//  Description : Directed self-checking bench for captura_operandos.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_captura_operandos;

    localparam int RELEASE_CYCLES = 16384;

    logic        clk;
    logic        rst;
    logic [3:0]  dato;
    logic        dato_ctrl;
    logic [11:0] disp;
    logic [1:0]  n_dig;
    logic [11:0] num_a;
    logic [11:0] num_b;
    logic [1:0]  fase;
    logic        listo;

    int checks;
    int errors;
    int listo_cnt;

    captura_operandos #(.RELEASE_CYCLES(RELEASE_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .dato      (dato),
        .dato_ctrl (dato_ctrl),
        .disp      (disp),
        .n_dig     (n_dig),
        .num_a     (num_a),
        .num_b     (num_b),
        .fase      (fase),
        .listo     (listo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with listo high, sampled away from the active edge
    always @(negedge clk) begin
        if (listo) listo_cnt = listo_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle strobe; returns at the negedge after the capturing posedge
    task automatic strobe(input logic [3:0] code);
        dato      = code;
        dato_ctrl = 1'b1;
        @(negedge clk);
        dato_ctrl = 1'b0;
    endtask

    task automatic press(input logic [3:0] code);
        strobe(code);
        idle(1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        dato_ctrl = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        dato      = 4'd8;
        dato_ctrl = 1'b1;
        idle(2);
        checks++; if (disp !== 12'h000) begin errors++; $display("FAIL reset_disp: got %h expected 000", disp); end
        checks++; if (n_dig !== 2'd0) begin errors++; $display("FAIL reset_n_dig: got %0d expected 0", n_dig); end
        checks++; if ({num_a, num_b} !== 24'h0) begin errors++; $display("FAIL reset_nums: got %h/%h expected 000/000", num_a, num_b); end
        checks++; if ({fase, listo} !== 3'b000) begin errors++; $display("FAIL reset_fase_listo: got %b/%b expected 00/0", fase, listo); end
        rst       = 1'b0;
        dato_ctrl = 1'b0;
        idle(1);
        checks++; if (n_dig !== 2'd0) begin errors++; $display("FAIL reset_strobe_dropped: n_dig got %0d expected 0", n_dig); end
        strobe(4'd8);
        checks++; if (disp !== 12'h008) begin errors++; $display("FAIL first_press: got %h expected 008", disp); end
    endtask

    task automatic test_digits();
        do_reset();
        press(4'd1); press(4'd2); press(4'd3);
        checks++; if (disp !== 12'h123) begin errors++; $display("FAIL digits_disp: got %h expected 123", disp); end
        checks++; if (n_dig !== 2'd3) begin errors++; $display("FAIL digits_n_dig: got %0d expected 3", n_dig); end
        press(4'd4);
        checks++; if ({disp, n_dig} !== {12'h123, 2'd3}) begin errors++; $display("FAIL digits_full: got %h/%0d expected 123/3", disp, n_dig); end
        press(4'd10);
        checks++; if ({num_a, fase, n_dig, disp} !== {12'h123, 2'b01, 2'd0, 12'h000}) begin
            errors++; $display("FAIL commit_a: got num_a=%h fase=%b n=%0d disp=%h expected 123/01/0/000", num_a, fase, n_dig, disp);
        end
    endtask

    task automatic test_leading_zero();
        do_reset();
        press(4'd0); press(4'd5);
        checks++; if ({disp, n_dig} !== {12'h005, 2'd2}) begin errors++; $display("FAIL leading_zero: got %h/%0d expected 005/2", disp, n_dig); end
    endtask

    task automatic test_repeat_filter();
        do_reset();
        strobe(4'd7);
        idle(8007); strobe(4'd7);
        idle(8007); strobe(4'd7);
        checks++; if ({disp, n_dig} !== {12'h007, 2'd1}) begin errors++; $display("FAIL repeat_held: got %h/%0d expected 007/1", disp, n_dig); end
        idle(RELEASE_CYCLES - 1); strobe(4'd7);
        checks++; if (disp !== 12'h007) begin errors++; $display("FAIL repeat_one_short: got %h expected 007", disp); end
        idle(RELEASE_CYCLES); strobe(4'd7);
        checks++; if ({disp, n_dig} !== {12'h077, 2'd2}) begin errors++; $display("FAIL repeat_released: got %h/%0d expected 077/2", disp, n_dig); end
        strobe(4'd5);
        checks++; if (disp !== 12'h775) begin errors++; $display("FAIL repeat_new_code: got %h expected 775", disp); end
    endtask

    task automatic test_operands();
        int base;
        do_reset();
        base = listo_cnt;
        press(4'd4); press(4'd2); press(4'd10); press(4'd9);
        checks++; if ({num_a, fase} !== {12'h042, 2'b01}) begin errors++; $display("FAIL op_a: got %h/%b expected 042/01", num_a, fase); end
        strobe(4'd15);
        checks++; if (listo !== 1'b1) begin errors++; $display("FAIL op_listo_high: got %b expected 1", listo); end
        idle(1);
        checks++; if (listo !== 1'b0) begin errors++; $display("FAIL op_listo_low: got %b expected 0", listo); end
        checks++; if ({num_b, fase, disp} !== {12'h009, 2'b10, 12'h009}) begin
            errors++; $display("FAIL op_b: got num_b=%h fase=%b disp=%h expected 009/10/009", num_b, fase, disp);
        end
        press(4'd10); press(4'd15); press(4'd13);
        checks++; if ({fase, num_a, num_b} !== {2'b10, 12'h042, 12'h009}) begin
            errors++; $display("FAIL listo_ignore: got fase=%b %h/%h expected 10 042/009", fase, num_a, num_b);
        end
        checks++; if (listo_cnt - base !== 1) begin errors++; $display("FAIL listo_pulses: got %0d expected 1", listo_cnt - base); end
        press(4'd3);
        checks++; if ({fase, disp, n_dig, num_a, num_b} !== {2'b00, 12'h003, 2'd1, 12'h042, 12'h009}) begin
            errors++; $display("FAIL listo_digit: got fase=%b disp=%h n=%0d %h/%h expected 00 003 1 042/009", fase, disp, n_dig, num_a, num_b);
        end
    endtask

    task automatic test_clear();
        do_reset();
        press(4'd5); press(4'd11); press(4'd6);
        checks++; if ({disp, n_dig, fase} !== {12'h006, 2'd1, 2'b00}) begin errors++; $display("FAIL clear_entry: got %h/%0d/%b expected 006/1/00", disp, n_dig, fase); end
        press(4'd10); press(4'd1); press(4'd15);
        checks++; if ({fase, num_a, num_b} !== {2'b10, 12'h006, 12'h001}) begin errors++; $display("FAIL clear_setup: got %b %h/%h expected 10 006/001", fase, num_a, num_b); end
        press(4'd11);
        checks++; if ({fase, num_a, num_b, disp, n_dig} !== {2'b00, 36'h0, 2'd0}) begin
            errors++; $display("FAIL clear_listo: got fase=%b %h/%h disp=%h n=%0d expected 00 000/000 000 0", fase, num_a, num_b, disp, n_dig);
        end
    endtask

    task automatic test_ignored_keys();
        do_reset();
        press(4'd1); press(4'd13); press(4'd14); press(4'd15); press(4'd2);
        checks++; if ({disp, n_dig, fase} !== {12'h012, 2'd2, 2'b00}) begin errors++; $display("FAIL ignored_keys: got %h/%0d/%b expected 012/2/00", disp, n_dig, fase); end
    endtask

    task automatic test_backspace();
        do_reset();
        press(4'd12);
        checks++; if ({disp, n_dig} !== {12'h000, 2'd0}) begin errors++; $display("FAIL c_empty: got %h/%0d expected 000/0", disp, n_dig); end
        do_reset();
        press(4'd1); press(4'd2); press(4'd12); press(4'd3);
`ifdef KEY_BACKSPACE_EN
        checks++; if ({disp, n_dig} !== {12'h013, 2'd2}) begin errors++; $display("FAIL backspace: got %h/%0d expected 013/2", disp, n_dig); end
`else
        checks++; if ({disp, n_dig} !== {12'h123, 2'd3}) begin errors++; $display("FAIL c_ignored: got %h/%0d expected 123/3", disp, n_dig); end
`endif
    endtask

    task automatic test_mid_entry_reset();
        do_reset();
        press(4'd1); press(4'd2);
        rst       = 1'b1;
        dato      = 4'd8;
        dato_ctrl = 1'b1;
        idle(1);
        rst       = 1'b0;
        dato_ctrl = 1'b0;
        checks++; if ({disp, n_dig, fase, listo} !== {12'h000, 2'd0, 2'b00, 1'b0}) begin
            errors++; $display("FAIL mid_reset: got disp=%h n=%0d fase=%b listo=%b expected 000/0/00/0", disp, n_dig, fase, listo);
        end
        idle(1);
        checks++; if (disp !== 12'h000) begin errors++; $display("FAIL mid_reset_after: got %h expected 000", disp); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        listo_cnt = 0;
        rst       = 1'b1;
        dato      = 4'd0;
        dato_ctrl = 1'b0;
        test_reset();
        test_digits();
        test_leading_zero();
        test_repeat_filter();
        test_operands();
        test_clear();
        test_ignored_keys();
        test_backspace();
        test_mid_entry_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
